// File: rtl/transmitter_i2s_if.sv
// Stereo sample handshake bundle between a sample source and the I2S transmitter.
// Latency: none (wires only).
// Backpressure: source holds data_valid and the pair until it sees data_ready at a clock edge.
//
// Signals:
//   left_data, right_data : stereo pair, two's complement, DATA_SIZE bits each
//   data_valid            : source has a pair on left_data/right_data
//   data_ready            : transmitter holding buffer is empty
interface transmitter_i2s_if #(
  parameter int DATA_SIZE = 24
) ();
  logic [DATA_SIZE-1:0] left_data;
  logic [DATA_SIZE-1:0] right_data;
  logic                 data_valid;
  logic                 data_ready;

  // Sample source side
  modport master (
    output left_data,
    output right_data,
    output data_valid,
    input  data_ready
  );

  // Transmitter side
  modport slave (
    input  left_data,
    input  right_data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/transmitter_i2s.sv
// I2S transmitter: 64-clk frame, 32 slots per channel, MSB first, one stereo pair buffered.
// Latency: an accepted pair's left MSB appears on i2s_sd at the next bit_cnt = 0 (1..64 clk).
// Backpressure: data_ready drops while the single holding buffer is full; it frees at frame start.
//
// Ports:
//   clk        : serial bit clock (SCK), the only clock
//   rst_n      : asynchronous active-low reset
//   bus        : transmitter_i2s_if.slave (left_data, right_data, data_valid, data_ready)
//   i2s_ws     : word select, 0 = left, 1 = right (registered)
//   i2s_sd     : serial data, MSB first (registered)
//   underrun   : one-cycle pulse at bit_cnt = 0 when a frame starts with no new pair
// Build option: define TRANSMITTER_I2S_REPEAT_EN to re-send the previous pair on underrun
// instead of sending silence.
module transmitter_i2s #(
  parameter int DATA_SIZE = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  transmitter_i2s_if.slave   bus,
  output logic               i2s_ws,
  output logic               i2s_sd,
  output logic               underrun
);

  localparam logic [6:0] LEFT_END  = 7'(DATA_SIZE);
  localparam logic [6:0] RIGHT_END = 7'(32 + DATA_SIZE);

  logic [5:0]           bit_cnt;
  logic                 full;
  logic                 first_frame;
  logic [DATA_SIZE-1:0] hold_l, hold_r;
  logic [DATA_SIZE-1:0] left_sr, right_sr;
`ifdef TRANSMITTER_I2S_REPEAT_EN
  logic [DATA_SIZE-1:0] last_l, last_r;
`endif

  logic                 frame_end;
  logic                 accept;
  logic [5:0]           nxt_cnt;
  logic [6:0]           nxt_cnt7;
  logic [DATA_SIZE-1:0] load_l, load_r;
  logic [DATA_SIZE-1:0] left_sr_nxt, right_sr_nxt;
  logic                 sd_nxt;
  logic                 ws_nxt;

  assign frame_end      = (bit_cnt == 6'd63);
  assign accept         = bus.data_valid && !full;
  assign bus.data_ready = !full;

  // Outputs are computed for the count the next edge moves to, so the
  // registered i2s_sd/i2s_ws line up with bit_cnt during the following cycle.
  always_comb begin
    nxt_cnt      = bit_cnt + 6'd1;
    nxt_cnt7     = {1'b0, nxt_cnt};
    left_sr_nxt  = left_sr;
    right_sr_nxt = right_sr;
    sd_nxt       = 1'b0;

    if (full) begin
      load_l = hold_l;
      load_r = hold_r;
    end else begin
`ifdef TRANSMITTER_I2S_REPEAT_EN
      load_l = last_l;
      load_r = last_r;
`else
      load_l = '0;
      load_r = '0;
`endif
    end

    if (frame_end) begin
      // Left MSB goes out in the same edge that loads the frame.
      left_sr_nxt  = load_l;
      right_sr_nxt = load_r;
      sd_nxt       = load_l[DATA_SIZE-1];
    end else if (nxt_cnt7 < LEFT_END) begin
      // Remaining left bits: the bit below the current MSB, then shift.
      left_sr_nxt  = left_sr << 1;
      sd_nxt       = left_sr[DATA_SIZE-2];
    end else if (nxt_cnt7 == 7'd32) begin
      sd_nxt       = right_sr[DATA_SIZE-1];
    end else if ((nxt_cnt7 > 7'd32) && (nxt_cnt7 < RIGHT_END)) begin
      right_sr_nxt = right_sr << 1;
      sd_nxt       = right_sr[DATA_SIZE-2];
    end

    // WS leads each channel MSB by one clk: high for counts 31..62.
    ws_nxt = (nxt_cnt >= 6'd31) && (nxt_cnt != 6'd63);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= 6'd63;
      i2s_ws      <= 1'b0;
      i2s_sd      <= 1'b0;
      underrun    <= 1'b0;
      full        <= 1'b0;
      first_frame <= 1'b1;
      hold_l      <= '0;
      hold_r      <= '0;
      left_sr     <= '0;
      right_sr    <= '0;
`ifdef TRANSMITTER_I2S_REPEAT_EN
      last_l      <= '0;
      last_r      <= '0;
`endif
    end else begin
      bit_cnt  <= nxt_cnt;
      i2s_ws   <= ws_nxt;
      i2s_sd   <= sd_nxt;
      left_sr  <= left_sr_nxt;
      right_sr <= right_sr_nxt;
      // The first frame after reset never has a pair, so it is not an underrun.
      underrun <= frame_end && !full && !first_frame;
      if (frame_end) begin
        first_frame <= 1'b0;
      end

      // accept implies the buffer was empty, so it never races the drain below;
      // a pair arriving on the load edge itself is kept for the next frame.
      if (accept) begin
        hold_l <= bus.left_data;
        hold_r <= bus.right_data;
        full   <= 1'b1;
      end else if (frame_end && full) begin
        full   <= 1'b0;
      end

`ifdef TRANSMITTER_I2S_REPEAT_EN
      if (frame_end && full) begin
        last_l <= hold_l;
        last_r <= hold_r;
      end
`endif
    end
  end

endmodule
